// File: rtl/hwag_pkg.sv
// hwag_pkg: shared types and constants for the HWAG crank/cam path.
// Provides the crank generator FSM state type, default wheel geometry,
// minimum tooth period and the number of slots the cam signal spans.
package hwag_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StToothHi,
    StToothLo,
    StGap
  } crank_gen_state_t;

  localparam int unsigned CRANK_TEETH_DEF  = 60;
  localparam int unsigned CRANK_GAP_DEF    = 2;
  localparam int unsigned CRANK_PERIOD_MIN = 2;
  localparam int unsigned CAM_SLOTS        = 5;

endpackage

// File: rtl/crank_slot_timer.sv
// crank_slot_timer: per-slot cycle counter with shadow/active period registers.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   period_i     - requested tooth period (clk cycles), captured on period_wr_i
//   period_wr_i  - one-cycle load strobe for the shadow period (clamped to >= 2)
//   start_i      - IDLE->run transition: counter at 0, active period <= shadow
//   run_i        - generator is running; counter advances
//   half_hit_o   - count == (P>>1)-1, last cycle of the high phase
//   pre_end_o    - count == P-2, one cycle before the slot boundary
//   slot_end_o   - count == P-1, slot boundary
module crank_slot_timer
  import hwag_pkg::*;
#(
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] period_i,
  input  logic             period_wr_i,
  input  logic             start_i,
  input  logic             run_i,
  output logic             half_hit_o,
  output logic             pre_end_o,
  output logic             slot_end_o
);

  localparam logic [WIDTH-1:0] PeriodMin = WIDTH'(CRANK_PERIOD_MIN);

  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign half_hit_o = (cnt_q == (active_q >> 1) - WIDTH'(1));
  assign pre_end_o  = (cnt_q == active_q - WIDTH'(2));
  assign slot_end_o = (cnt_q == active_q - WIDTH'(1));

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    if (period_wr_i) begin
      shadow_d = (period_i < PeriodMin) ? PeriodMin : period_i;
    end
    // The active period only ever takes the registered shadow, so a strobe
    // landing on a boundary cycle applies one slot later.
    if (start_i) begin
      active_d = shadow_q;
      cnt_d    = '0;
    end else if (run_i) begin
      if (slot_end_o) begin
        active_d = shadow_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= PeriodMin;
      active_q <= PeriodMin;
      cnt_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/crank_wheel_gen.sv
// crank_wheel_gen: synthetic TEETH-GAP crank trigger-wheel generator.
// Each revolution is TEETH slots of `period` clocks; the last GAP slots are
// missing teeth. Optional cam output enabled by macro CRANK_WHEEL_GEN_CAM_EN
// (one cam pulse over slots 0..CAM_SLOTS-1 every second revolution).
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   enable      - level run request
//   period      - tooth period in clocks, loaded on period_wr
//   period_wr   - one-cycle shadow period load strobe
//   tooth       - crank signal (1 = tooth)
//   slot_num    - current slot index 0..TEETH-1
//   gap_active  - in a missing-tooth slot
//   rev_pulse   - one-cycle pulse on the last cycle of each revolution
//   busy        - FSM not idle
//   cam         - cam phase signal (0 when the cam feature is not built)
module crank_wheel_gen
  import hwag_pkg::*;
#(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned TEETH = CRANK_TEETH_DEF,
  parameter int unsigned GAP   = CRANK_GAP_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [WIDTH-1:0]         period,
  input  logic                     period_wr,
  output logic                     tooth,
  output logic [$clog2(TEETH)-1:0] slot_num,
  output logic                     gap_active,
  output logic                     rev_pulse,
  output logic                     busy,
  output logic                     cam
);

  localparam int unsigned SlotW = $clog2(TEETH);
  localparam logic [SlotW-1:0] FirstGap = SlotW'(TEETH - GAP);
  localparam logic [SlotW-1:0] LastSlot = SlotW'(TEETH - 1);

  crank_gen_state_t state_q, state_d;
  logic [SlotW-1:0] slot_q, slot_d, slot_inc;
  logic             tooth_q, tooth_d;
  logic             gap_active_q, gap_active_d;
  logic             rev_pulse_q, rev_pulse_d;
  logic             busy_q, busy_d;
  logic             half_hit, pre_end, slot_end;

  crank_slot_timer #(
    .WIDTH(WIDTH)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .period_i   (period),
    .period_wr_i(period_wr),
    .start_i    ((state_q == StIdle) && enable),
    .run_i      (state_q != StIdle),
    .half_hit_o (half_hit),
    .pre_end_o  (pre_end),
    .slot_end_o (slot_end)
  );

  assign slot_inc = slot_q + SlotW'(1);

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    rev_pulse_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        slot_d = '0;
        if (enable) state_d = StToothHi;
      end
      StToothHi: begin
        if (half_hit) state_d = StToothLo;
      end
      StToothLo: begin
        if (slot_end) begin
          // Once the gap starts it always runs to the end of the revolution.
          if (slot_inc >= FirstGap) begin
            state_d = StGap;
            slot_d  = slot_inc;
          end else if (enable) begin
            state_d = StToothHi;
            slot_d  = slot_inc;
          end else begin
            state_d = StIdle;
            slot_d  = '0;
          end
        end
      end
      StGap: begin
        // Registered pulse: raise it from the cycle before the final one.
        if ((slot_q == LastSlot) && pre_end) rev_pulse_d = 1'b1;
        if (slot_end) begin
          if (slot_q == LastSlot) begin
            slot_d  = '0;
            state_d = enable ? StToothHi : StIdle;
          end else begin
            slot_d = slot_inc;
          end
        end
      end
      default: begin
        state_d = StIdle;
        slot_d  = '0;
      end
    endcase
    tooth_d      = (state_d == StToothHi);
    gap_active_d = (state_d == StGap);
    busy_d       = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      slot_q       <= '0;
      tooth_q      <= 1'b0;
      gap_active_q <= 1'b0;
      rev_pulse_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      tooth_q      <= tooth_d;
      gap_active_q <= gap_active_d;
      rev_pulse_q  <= rev_pulse_d;
      busy_q       <= busy_d;
    end
  end

  assign tooth      = tooth_q;
  assign slot_num   = slot_q;
  assign gap_active = gap_active_q;
  assign rev_pulse  = rev_pulse_q;
  assign busy       = busy_q;

`ifdef CRANK_WHEEL_GEN_CAM_EN
  logic parity_q, parity_d;
  logic cam_q, cam_d;

  always_comb begin
    // Parity flips as the wrap to slot 0 happens; idle always restarts at 0.
    parity_d = parity_q ^ rev_pulse_q;
    if (state_d == StIdle) parity_d = 1'b0;
    cam_d = (state_d != StIdle) && (32'(slot_d) < CAM_SLOTS) && !parity_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
      cam_q    <= 1'b0;
    end else begin
      parity_q <= parity_d;
      cam_q    <= cam_d;
    end
  end

  assign cam = cam_q;
`else
  assign cam = 1'b0;
`endif

endmodule
